abs_diff_pipe: RTL

Streaming, parametrised absolute-difference unit. It computes |a − b| for WIDTH-bit unsigned operands through a 2-stage valid/ready pipeline. A per-transaction mode bit selects between the exact result and an approximate result with TRUNC LSBs forced to zero. An optional error monitor counts results and flags approximations whose error exceeds the threshold ET, which lets approximate arithmetic be characterised in-system.

---
 rtl/abs_diff_pkg.sv | 20 ++
 rtl/abs_diff_errmon.sv | 65 ++++++
 rtl/abs_diff_pipe.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/abs_diff_pkg.sv
// Shared defaults, mode encoding and truncation-mask helper for abs_diff_pipe.
package abs_diff_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_TRUNC = 2;
  localparam int unsigned DEF_ET    = 1;
  localparam int unsigned DEF_CNT_W = 16;
  localparam int unsigned MASK_W    = 64;

  typedef enum logic {
    MODE_EXACT  = 1'b0,
    MODE_APPROX = 1'b1
  } abs_mode_t;

  // Mask covering the TRUNC low-order bits; callers cast down to their width.
  function automatic logic [MASK_W-1:0] trunc_mask(input int unsigned trunc);
    return (MASK_W'(1) << trunc) - MASK_W'(1);
  endfunction

endpackage

// File: rtl/abs_diff_errmon.sv
// Result/violation counters with saturation and a sticky error flag.
// Only instantiated when ABS_DIFF_PIPE_ERRMON_EN is defined.
module abs_diff_errmon
  import abs_diff_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned ET    = DEF_ET,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hs_i,
  input  abs_mode_t        mode_i,
  input  logic [WIDTH-1:0] err_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] res_cnt_o,
  output logic [CNT_W-1:0] viol_cnt_o,
  output logic             err_flag_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] res_q, res_d;
  logic [CNT_W-1:0] viol_q, viol_d;
  logic             flag_q, flag_d;
  logic             viol_c;

  assign viol_c = hs_i && (mode_i == MODE_APPROX) && (32'(err_i) > ET);

  // Next-state: clear dominates, otherwise count handshakes and violations.
  always_comb begin
    res_d  = res_q;
    viol_d = viol_q;
    flag_d = flag_q;
    if (clr_i) begin
      res_d  = '0;
      viol_d = '0;
      flag_d = 1'b0;
    end else begin
      if (hs_i && (res_q != CNT_MAX)) res_d = res_q + CNT_W'(1);
      if (viol_c) begin
        if (viol_q != CNT_MAX) viol_d = viol_q + CNT_W'(1);
        flag_d = 1'b1;
      end
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q  <= '0;
      viol_q <= '0;
      flag_q <= 1'b0;
    end else begin
      res_q  <= res_d;
      viol_q <= viol_d;
      flag_q <= flag_d;
    end
  end

  assign res_cnt_o  = res_q;
  assign viol_cnt_o = viol_q;
  assign err_flag_o = flag_q;

endmodule

// File: rtl/abs_diff_pipe.sv
// Two-stage valid/ready |a - b| pipeline with optional LSB truncation.
// Define ABS_DIFF_PIPE_ERRMON_EN to build the result/violation monitor.
module abs_diff_pipe
  import abs_diff_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned TRUNC = DEF_TRUNC,
  parameter int unsigned ET    = DEF_ET,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_approx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] res_cnt,
  output logic [CNT_W-1:0] viol_cnt,
  output logic             err_flag
);

  localparam logic [WIDTH-1:0] LSB_MASK = WIDTH'(trunc_mask(TRUNC));

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH:0]   s1_amb_q, s1_amb_d;
  logic [WIDTH:0]   s1_bma_q, s1_bma_d;
  logic             s1_borrow_q, s1_borrow_d;
  abs_mode_t        s1_mode_q, s1_mode_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_diff_q, s2_diff_d;
  logic [WIDTH-1:0] s2_err_q, s2_err_d;
  abs_mode_t        s2_mode_q, s2_mode_d;

  logic             s1_adv_c, s2_adv_c, out_hs_c;
  logic [WIDTH:0]   amb_c, bma_c;
  logic [WIDTH-1:0] exact_c;

  // A stage moves when it is empty or its successor moves.
  assign s2_adv_c = !s2_valid_q || out_ready;
  assign s1_adv_c = !s1_valid_q || s2_adv_c;
  assign in_ready = s1_adv_c;
  assign out_hs_c = s2_valid_q && out_ready;

  assign amb_c   = {1'b0, in_a} - {1'b0, in_b};
  assign bma_c   = {1'b0, in_b} - {1'b0, in_a};
  assign exact_c = s1_borrow_q ? s1_bma_q[WIDTH-1:0] : s1_amb_q[WIDTH-1:0];

  // Stage 1: capture both signed differences, borrow and mode.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_amb_d    = s1_amb_q;
    s1_bma_d    = s1_bma_q;
    s1_borrow_d = s1_borrow_q;
    s1_mode_d   = s1_mode_q;
    if (s1_adv_c) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_amb_d    = amb_c;
        s1_bma_d    = bma_c;
        s1_borrow_d = amb_c[WIDTH];
        s1_mode_d   = in_approx ? MODE_APPROX : MODE_EXACT;
      end
    end
  end

  // Stage 2: pick the non-negative difference and apply truncation.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_diff_d  = s2_diff_q;
    s2_err_d   = s2_err_q;
    s2_mode_d  = s2_mode_q;
    if (s2_adv_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_diff_d = (s1_mode_q == MODE_APPROX) ? (exact_c & ~LSB_MASK) : exact_c;
        s2_err_d  = exact_c & LSB_MASK;
        s2_mode_d = s1_mode_q;
      end
    end
  end

  // Pipeline registers; reset discards anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_amb_q    <= '0;
      s1_bma_q    <= '0;
      s1_borrow_q <= 1'b0;
      s1_mode_q   <= MODE_EXACT;
      s2_valid_q  <= 1'b0;
      s2_diff_q   <= '0;
      s2_err_q    <= '0;
      s2_mode_q   <= MODE_EXACT;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_amb_q    <= s1_amb_d;
      s1_bma_q    <= s1_bma_d;
      s1_borrow_q <= s1_borrow_d;
      s1_mode_q   <= s1_mode_d;
      s2_valid_q  <= s2_valid_d;
      s2_diff_q   <= s2_diff_d;
      s2_err_q    <= s2_err_d;
      s2_mode_q   <= s2_mode_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_diff  = s2_diff_q;

`ifdef ABS_DIFF_PIPE_ERRMON_EN
  abs_diff_errmon #(
    .WIDTH(WIDTH),
    .ET   (ET),
    .CNT_W(CNT_W)
  ) u_errmon (
    .clk       (clk),
    .rst       (rst),
    .hs_i      (out_hs_c),
    .mode_i    (s2_mode_q),
    .err_i     (s2_err_q),
    .clr_i     (cnt_clr),
    .res_cnt_o (res_cnt),
    .viol_cnt_o(viol_cnt),
    .err_flag_o(err_flag)
  );

  // The sign bits are carried only so the captured differences are complete.
  logic unused_ok;
  assign unused_ok = ^{s1_amb_q[WIDTH], s1_bma_q[WIDTH]};
`else
  assign res_cnt  = '0;
  assign viol_cnt = '0;
  assign err_flag = 1'b0;

  // Monitor-only signals have no load in this build.
  logic unused_ok;
  assign unused_ok = ^{cnt_clr, out_hs_c, s2_mode_q, s2_err_q,
                       s1_amb_q[WIDTH], s1_bma_q[WIDTH], 1'(ET)};
`endif

endmodule
